// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, FSM encoding, FIPS 180-4 initial value and round functions.
package sha256_pkg;

  localparam int ROUNDS = 64;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 6;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // H0 sits in the top word, matching hash_in/hash_out packing
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t sig_S0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t sig_S1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t sig_s0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sig_s1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round_core_if.sv
// Block-in / digest-out handshakes plus the K ROM index/data pair for sha256_round_core.
interface sha256_round_core_if;
  import sha256_pkg::*;

  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic [255:0] hash_in;
  logic         first_blk;
  logic [6:0]   k_idx;
  word_t        k_in;
  logic         hash_valid;
  logic         hash_ready;
  logic [255:0] hash_out;
  logic         busy;

  modport slave (
    input  blk_valid, blk_data, hash_in, first_blk, k_in, hash_ready,
    output blk_ready, k_idx, hash_valid, hash_out, busy
  );

  modport master (
    output blk_valid, blk_data, hash_in, first_blk, k_in, hash_ready,
    input  blk_ready, k_idx, hash_valid, hash_out, busy
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// Sliding 16-word message schedule window; r_w[0] is the word consumed this round.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [511:0] i_blk_data,
  output word_t        o_wt
);

  logic [15:0][WORD_W-1:0] r_w;
  word_t                   w_new;

  // Tail word is produced every round; it only reaches r_w[0] from t=16 on
  assign w_new = sig_s1(r_w[14]) + r_w[9] + sig_s0(r_w[1]) + r_w[0];
  assign o_wt  = r_w[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w <= '0;
    end else if (i_load) begin
      for (int i = 0; i < 16; i++) r_w[i] <= i_blk_data[511-32*i -: 32];
    end else if (i_shift) begin
      r_w <= {w_new, r_w[15:1]};
    end
  end

endmodule

// File: rtl/sha256_round_core.sv
// Iterative SHA-256 compression, one round per clock, K fetched from an external ROM.
// Optional SHA256_IV_EN: first_blk=1 loads the FIPS 180-4 IV instead of hash_in.
module sha256_round_core
  import sha256_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  sha256_round_core_if.slave   bus
);

  state_t                  r_state, w_nxt;
  logic [CNT_W-1:0]        r_cnt;
  word_t                   r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [7:0][WORD_W-1:0]  r_hv;
  logic [255:0]            r_hout;
  logic [255:0]            w_init;
  logic [7:0][WORD_W-1:0]  w_work, w_sum;
  logic                    w_accept, w_shift;
  word_t                   w_wt, w_t1, w_t2;

`ifdef SHA256_IV_EN
  assign w_init = bus.first_blk ? IV : bus.hash_in;
`else
  assign w_init = bus.hash_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (bus.blk_valid) begin
                  w_accept = 1'b1;
                  w_nxt    = ST_ROUND;
                end
      ST_ROUND: if (r_cnt == CNT_W'(ROUNDS-1)) w_nxt = ST_FINAL;
      ST_FINAL: w_nxt = ST_DONE;
      ST_DONE:  if (bus.hash_ready) w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  assign w_shift        = (r_state == ST_ROUND);
  assign bus.blk_ready  = (r_state == ST_IDLE);
  assign bus.hash_valid = (r_state == ST_DONE);
  assign bus.busy       = (r_state == ST_ROUND) || (r_state == ST_FINAL);
  assign bus.hash_out   = r_hout;
  // Counter is zero outside ROUND and wraps to zero after t=63
  assign bus.k_idx      = {1'b0, r_cnt};

  sha256_msg_schedule u_sched (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_shift    (w_shift),
    .i_blk_data (bus.blk_data),
    .o_wt       (w_wt)
  );

  assign w_t1 = r_h + sig_S1(r_e) + ch(r_e, r_f, r_g) + bus.k_in + w_wt;
  assign w_t2 = sig_S0(r_a) + maj(r_a, r_b, r_c);

  always_comb begin
    w_work = {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h};
    w_sum  = '0;
    for (int i = 0; i < 8; i++) w_sum[i] = r_hv[i] + w_work[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_a    <= '0; r_b <= '0; r_c <= '0; r_d <= '0;
      r_e    <= '0; r_f <= '0; r_g <= '0; r_h <= '0;
      r_hv   <= '0;
      r_hout <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_accept) begin
          r_cnt <= '0;
          r_hv  <= w_init;
          {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= w_init;
        end
        ST_ROUND: begin
          r_cnt <= r_cnt + 6'd1;
          r_h   <= r_g;
          r_g   <= r_f;
          r_f   <= r_e;
          r_e   <= r_d + w_t1;
          r_d   <= r_c;
          r_c   <= r_b;
          r_b   <= r_a;
          r_a   <= w_t1 + w_t2;
        end
        ST_FINAL: begin
          r_hv   <= w_sum;
          r_hout <= w_sum;
        end
        default: ;
      endcase
    end
  end

endmodule
